// File: rtl/moving_average_pkg.sv
// Shared types and default sizing for the moving_average block.
package moving_average_pkg;

  // Window fill state: FILL while fewer than DEPTH samples are held, RUN afterwards.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } ma_state_e;

  localparam int unsigned MA_WIDTH_DEFAULT      = 8;
  localparam int unsigned MA_LOG2_DEPTH_DEFAULT = 3;

endpackage

// File: rtl/moving_average_sample_ring.sv
// sample_ring: DEPTH-entry circular sample store, one write port and one
// combinational read port sharing a single pointer. Contents are never reset;
// the consumer masks stale entries while the window is filling.
module sample_ring
  import moving_average_pkg::*;
#(
  parameter int unsigned WIDTH      = MA_WIDTH_DEFAULT,
  parameter int unsigned LOG2_DEPTH = MA_LOG2_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [LOG2_DEPTH-1:0] ptr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the accepted sample at the slot the pointer currently addresses.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ptr] <= wr_data;
    end
  end

  // The slot about to be overwritten is the oldest sample in the window.
  assign rd_data = mem_q[ptr];

endmodule

// File: rtl/moving_average.sv
// moving_average: running-sum moving average over a 2^LOG2_DEPTH window.
// Optional build macro MOVING_AVERAGE_ROUND_EN selects round-half-up instead
// of truncation for the average.
module moving_average
  import moving_average_pkg::*;
#(
  parameter int unsigned WIDTH      = MA_WIDTH_DEFAULT,
  parameter int unsigned LOG2_DEPTH = MA_LOG2_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sample_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] average_out,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] LAST_FILL = (LOG2_DEPTH+1)'(DEPTH - 1);

  ma_state_e              state_q, state_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [LOG2_DEPTH-1:0]  ptr_q, ptr_d;
  logic [LOG2_DEPTH:0]    fill_cnt_q, fill_cnt_d;
  logic                   acc_q, acc_d;
  logic [WIDTH-1:0]       avg_q, avg_d;
  logic                   out_valid_q, out_valid_d;

  logic [WIDTH-1:0]       ring_rd_s;
  logic [WIDTH-1:0]       oldest_s;
  logic                   accept_s;
  logic [WIDTH-1:0]       avg_calc_s;

  assign accept_s = in_valid & ~clear;

  sample_ring #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .wr_en   (accept_s),
    .ptr     (ptr_q),
    .wr_data (sample_in),
    .rd_data (ring_rd_s)
  );

  // While filling, the slot being replaced holds no real sample: treat it as zero.
  always_comb begin
    if (state_q == RUN) begin
      oldest_s = ring_rd_s;
    end else begin
      oldest_s = {WIDTH{1'b0}};
    end
  end

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam logic [SUM_W:0] ROUND_HALF = (SUM_W+1)'(1) << (LOG2_DEPTH - 1);
  logic [SUM_W:0] rounded_s;
  // Round half up; the sum's maximum plus the half step still fits below bit SUM_W.
  assign rounded_s  = {1'b0, sum_q} + ROUND_HALF;
  assign avg_calc_s = rounded_s[SUM_W-1:LOG2_DEPTH];
`else
  // Truncating divide by the window depth.
  assign avg_calc_s = sum_q[SUM_W-1:LOG2_DEPTH];
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave FILL on the edge accepting the DEPTH-th sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (clear) begin
          state_d = FILL;
        end else if (accept_s && (fill_cnt_q == LAST_FILL)) begin
          state_d = RUN;
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = FILL;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // FSM output: window is full exactly while in RUN.
  always_comb begin
    full = (state_q == RUN);
  end

  // Datapath next state: running sum, pointer, fill count and the output stage.
  always_comb begin
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    fill_cnt_d  = fill_cnt_q;
    acc_d       = 1'b0;
    avg_d       = avg_q;
    out_valid_d = 1'b0;
    if (clear) begin
      sum_d      = {SUM_W{1'b0}};
      ptr_d      = {LOG2_DEPTH{1'b0}};
      fill_cnt_d = {(LOG2_DEPTH+1){1'b0}};
    end else begin
      // Publish the sum produced by the previous accepting edge.
      if (acc_q) begin
        avg_d       = avg_calc_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
      if (in_valid) begin
        sum_d = sum_q + {{LOG2_DEPTH{1'b0}}, sample_in} - {{LOG2_DEPTH{1'b0}}, oldest_s};
        ptr_d = ptr_q + LOG2_DEPTH'(1);
        acc_d = 1'b1;
        if (fill_cnt_q != DEPTH_CNT) begin
          fill_cnt_d = fill_cnt_q + (LOG2_DEPTH+1)'(1);
        end else begin
          fill_cnt_d = fill_cnt_q;
        end
      end else begin
        acc_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= {SUM_W{1'b0}};
      ptr_q       <= {LOG2_DEPTH{1'b0}};
      fill_cnt_q  <= {(LOG2_DEPTH+1){1'b0}};
      acc_q       <= 1'b0;
      avg_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      acc_q       <= acc_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign average_out = avg_q;
  assign out_valid   = out_valid_q;

endmodule

// File: doc/moving_average.md
MOVING_AVERAGE -- requirements
Module: moving_average

Interface
REQ-001 Parameter WIDTH, default 8: sample and average width in bits.
REQ-002 Parameter LOG2_DEPTH, default 3: window depth is DEPTH = 2^LOG2_DEPTH samples, legal range 1..8.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 CLEAR  input  1  synchronous window flush.
REQ-006 IN_VALID  input  1  SAMPLE_IN is accepted on this edge.
REQ-007 SAMPLE_IN  input  WIDTH  unsigned sample.
REQ-008 OUT_VALID  output  1  one-cycle pulse; AVERAGE_OUT was updated this cycle.
REQ-009 AVERAGE_OUT  output  WIDTH  registered window average.
REQ-010 FULL  output  1  high once DEPTH samples have been accepted since the last reset or CLEAR.

Function
REQ-011 Each accepted sample SHALL be written to a DEPTH-entry circular buffer at a write pointer, which increments modulo DEPTH and wraps from DEPTH-1 to 0.
REQ-012 The block SHALL keep a running sum SUM of width WIDTH+LOG2_DEPTH, updated on acceptance as SUM + SAMPLE_IN - OLDEST, where OLDEST is the entry being overwritten; SUM SHALL never overflow.
REQ-013 The block SHALL have a two-state FSM: FILL (reset state) and RUN.
REQ-014 In FILL, OLDEST SHALL be forced to zero regardless of buffer contents, so the average is zero-padded and no buffer clear is needed.
REQ-015 The FSM SHALL move FILL->RUN on the edge that accepts the DEPTH-th sample; FULL SHALL be high in RUN and low in FILL.
REQ-016 The average SHALL be the new SUM >> LOG2_DEPTH, truncated, unless REQ-026 applies.
REQ-017 Latency: AVERAGE_OUT and OUT_VALID SHALL update on the edge after the accepting edge.
REQ-018 While IN_VALID is low, SUM, the pointer, the FSM and AVERAGE_OUT SHALL hold, and OUT_VALID SHALL be 0.
REQ-019 CLEAR SHALL zero SUM, the pointer and the fill counter, return the FSM to FILL, and leave AVERAGE_OUT unchanged.
REQ-020 CLEAR together with IN_VALID: CLEAR wins, the sample is discarded, and OUT_VALID is 0 on the next edge.
REQ-021 A fill counter of LOG2_DEPTH+1 bits SHALL saturate at DEPTH.

Reset
REQ-022 Asserting RST_N low SHALL immediately set the FSM to FILL and clear SUM, the pointer and the fill counter.
REQ-023 Reset values: AVERAGE_OUT = 0, OUT_VALID = 0, FULL = 0.
REQ-024 Buffer contents SHALL NOT be reset, because REQ-014 masks them.
REQ-025 Reset deassertion mid-stream SHALL behave identically to power-up; the first accepted sample after it is sample 1.

Configuration
REQ-026 With MOVING_AVERAGE_ROUND_EN defined, the average SHALL be (SUM + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH, computed in WIDTH+LOG2_DEPTH+1 bits; no saturation logic is needed because the result is at most 2^WIDTH-1.
REQ-027 Without the macro, truncation per REQ-016 SHALL apply and no rounding adder SHALL be synthesised.

Structure
REQ-028 A shared package moving_average_pkg SHALL hold the FSM state typedef (FILL, RUN) and the default WIDTH/LOG2_DEPTH constants.
REQ-029 The circular buffer SHALL be a sub-module sample_ring, with one write port and one read port addressed by the same pointer, and combinational read of OLDEST.
REQ-030 The block SHALL be 120-400 lines of RTL, including sample_ring.

Verification (WIDTH=8, LOG2_DEPTH=3)
REQ-031 Reset check: hold RST_N low -> AVERAGE_OUT=0, OUT_VALID=0, FULL=0; no OUT_VALID on release.
REQ-032 Fill: eight consecutive samples of 80 -> AVERAGE_OUT 10,20,...,80, each one cycle after acceptance; FULL rises with the 8th.
REQ-033 Drain/wrap: continue with eight samples of 0 -> 70,60,...,0; then sixteen samples of 255 -> final 255, no overflow.
REQ-034 Gaps: the 80-stream with IN_VALID toggling every other cycle -> same value sequence; OUT_VALID only after accepted samples; outputs hold in between.
REQ-035 CLEAR collision: after FULL, CLEAR=1 with IN_VALID=1 and sample 200 -> OUT_VALID=0, FULL=0, AVERAGE_OUT unchanged; next sample 80 -> 10.
REQ-036 Rounding: after reset, single sample 4 -> 0 without the macro, 1 with MOVING_AVERAGE_ROUND_EN; single sample 3 -> 0 in both builds.
